// File: rtl/dcp_pkg.sv
// Shared definitions for the DCP receive path: ASCII constants, command codes,
// the scanner state encoding and the default data width.
package dcp_pkg;

  localparam int DW = 32;

  localparam logic [7:0] ASC_SP = 8'h20;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  // Single-character commands understood by the DCP controller
  localparam logic [7:0] CMD_READ  = 8'h72;  // 'r'
  localparam logic [7:0] CMD_WRITE = 8'h77;  // 'w'
  localparam logic [7:0] CMD_HELP  = 8'h3F;  // '?'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHAR,
    ST_HEX_SKIP,
    ST_HEX_ACC,
    ST_DRAIN,
    ST_ACK,
    ST_HOLD
  } scan_state_t;

  // CR or LF ends a command line
  function automatic logic is_eol(input logic [7:0] b);
    return (b == ASC_CR) || (b == ASC_LF);
  endfunction

endpackage

// File: rtl/dcp_hex_decode.sv
// Combinational ASCII to hex-nibble decoder: 0-9, A-F, a-f.
module dcp_hex_decode (
  input  logic [7:0] ch,
  output logic       is_hex,
  output logic [3:0] nibble
);

  // Letters share the low nibble pattern 1..6, offset by 9 to reach 10..15
  always_comb begin
    is_hex = 1'b0;
    nibble = 4'd0;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      is_hex = 1'b1;
      nibble = ch[3:0];
    end else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      is_hex = 1'b1;
      nibble = ch[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/dcp_scan.sv
// Receive-side token parser: turns the UART byte stream into single command
// characters or hex arguments on request of the DCP controller.
module dcp_scan #(
  parameter int DW         = dcp_pkg::DW,
  parameter int MAX_DIGITS = DW / 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    d_rx,
  input  logic          vld_rx,
  output logic          rdy_rx,
  input  logic          req_rx,
  input  logic          type_rx,
  output logic          ack_rx,
  output logic [DW-1:0] din_rx,
  output logic          flag_rx,
  output logic          err_rx
);

  import dcp_pkg::*;

  localparam int ACC_W = 4 * MAX_DIGITS;

  scan_state_t        state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DW-1:0]      din_d;
  logic               flag_d, err_d;
  logic               cr_q, cr_d;   // last accepted byte was CR
  logic               is_hex;
  logic [3:0]         nib;
  logic               take;

  dcp_hex_decode u_hex (
    .ch     (d_rx),
    .is_hex (is_hex),
    .nibble (nib)
  );

  // Bytes are only consumed while a token is being scanned and the request is
  // still held, so nothing is taken across an abort or a DCP mux switch.
  assign rdy_rx = req_rx && ((state_q == ST_CHAR) || (state_q == ST_HEX_SKIP) ||
                             (state_q == ST_HEX_ACC) || (state_q == ST_DRAIN));
  assign ack_rx = (state_q == ST_ACK);
  assign take   = vld_rx && rdy_rx;

  // Next-state and next-output decode for the token scanner
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    din_d   = din_rx;
    flag_d  = flag_rx;
    err_d   = err_rx;
    cr_d    = cr_q;
    if (take) cr_d = (d_rx == ASC_CR);

    case (state_q)
      ST_IDLE: begin
        if (req_rx) begin
          acc_d   = '0;
          flag_d  = 1'b0;
          err_d   = 1'b0;
          state_d = type_rx ? ST_HEX_SKIP : ST_CHAR;
        end
      end

      ST_CHAR: begin
        if (!req_rx) begin
          state_d = ST_IDLE;
        end else if (take && d_rx != ASC_SP && !is_eol(d_rx)) begin
          din_d   = DW'(d_rx);
          flag_d  = 1'b0;
          state_d = ST_ACK;
        end
      end

      ST_HEX_SKIP: begin
        if (!req_rx) begin
          state_d = ST_IDLE;
        end else if (take) begin
          if (is_hex) begin
            acc_d   = ACC_W'(nib);
            state_d = ST_HEX_ACC;
          end else if (is_eol(d_rx)) begin
            // LF of a CR/LF pair belongs to the previous line, not an empty argument
            if (!(d_rx == ASC_LF && cr_q)) begin
              din_d   = '0;
              flag_d  = 1'b1;
              state_d = ST_ACK;
            end
          end else if (d_rx != ASC_SP) begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_HEX_ACC: begin
        if (!req_rx) begin
          state_d = ST_IDLE;
        end else if (take) begin
          if (is_hex) begin
            acc_d = {acc_q[ACC_W-5:0], nib};
          end else if (d_rx == ASC_SP) begin
            din_d   = DW'(acc_q);
            flag_d  = 1'b0;
            state_d = ST_ACK;
          end else if (is_eol(d_rx)) begin
            din_d   = DW'(acc_q);
            flag_d  = 1'b1;
            state_d = ST_ACK;
          end else begin
            err_d   = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (!req_rx) begin
          state_d = ST_IDLE;
        end else if (take && is_eol(d_rx)) begin
          din_d   = '0;
          flag_d  = 1'b1;
          err_d   = 1'b1;
          state_d = ST_ACK;
        end
      end

      ST_ACK:  state_d = ST_HOLD;
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, accumulator and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      din_rx  <= '0;
      flag_rx <= 1'b0;
      err_rx  <= 1'b0;
      cr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      din_rx  <= din_d;
      flag_rx <= flag_d;
      err_rx  <= err_d;
      cr_q    <= cr_d;
    end
  end

endmodule

// File: tb/tb_dcp_scan.sv
// Directed testbench for dcp_scan.
module tb_dcp_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  d_rx = 8'h00;
  logic        vld_rx = 1'b0;
  logic        req_rx = 1'b0;
  logic        type_rx = 1'b0;
  logic        rdy_rx;
  logic        ack_rx;
  logic [31:0] din_rx;
  logic        flag_rx;
  logic        err_rx;

  int checks = 0;
  int failures = 0;
  int ack_cnt = 0;

  dcp_scan #(.DW(32), .MAX_DIGITS(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .d_rx    (d_rx),
    .vld_rx  (vld_rx),
    .rdy_rx  (rdy_rx),
    .req_rx  (req_rx),
    .type_rx (type_rx),
    .ack_rx  (ack_rx),
    .din_rx  (din_rx),
    .flag_rx (flag_rx),
    .err_rx  (err_rx)
  );

  always #5 clk = ~clk;

  // Count every ack pulse
  always @(posedge clk) if (ack_rx) ack_cnt <= ack_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte, starting at a falling edge; returns at the falling edge
  // after the rising edge that accepted it.
  task automatic push(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    d_rx = b;
    vld_rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bit go;
      #1;
      go = rdy_rx;
      @(negedge clk);
      if (go) begin
        ok = 1'b1;
        break;
      end
    end
    vld_rx = 1'b0;
  endtask

  // Full request: send the bytes (last one terminates the token), then check
  // ack latency, pulse width, ack count and results.
  task automatic token(input string tag, input bit t, input string s,
                       input logic [31:0] e_din, input logic e_flag, input logic e_err);
    bit ok, all_ok;
    int c0;
    all_ok = 1'b1;
    c0 = ack_cnt;
    req_rx = 1'b1;
    type_rx = t;
    for (int k = 0; k < s.len(); k++) begin
      push(s[k], ok);
      if (!ok) all_ok = 1'b0;
    end
    check({tag, "_accepted"}, 32'(all_ok), 32'd1);
    #1;
    check({tag, "_ack_latency"}, 32'(ack_rx), 32'd1);
    req_rx = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_ack_pulse"}, 32'(ack_rx), 32'd0);
    @(negedge clk);
    check({tag, "_ack_count"}, 32'(ack_cnt - c0), 32'd1);
    check({tag, "_din"}, din_rx, e_din);
    check({tag, "_flag"}, 32'(flag_rx), 32'(e_flag));
    check({tag, "_err"}, 32'(err_rx), 32'(e_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int c0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_rdy", 32'(rdy_rx), 32'd0);
    check("rst_ack", 32'(ack_rx), 32'd0);
    check("rst_din", din_rx, 32'd0);
    check("rst_flag", 32'(flag_rx), 32'd0);
    check("rst_err", 32'(err_rx), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Character with leading space
    token("t1_char", 1'b0, " D", 32'h44, 1'b0, 1'b0);
    // Hex terminated by space, mixed case
    token("t2_hex", 1'b1, "1A2b ", 32'h0000_1A2B, 1'b0, 1'b0);
    // Hex terminated by CR
    token("t2_hex_cr", 1'b1, "ff\015", 32'hFF, 1'b1, 1'b0);
    // LF right after a CR-terminated token is ignored
    token("t5_lf_skip", 1'b1, "\n5 ", 32'h5, 1'b0, 1'b0);
    // Bare CR gives an empty argument
    token("t5_empty", 1'b1, "\015", 32'h0, 1'b1, 1'b0);
    // Bad digit: drain through CR
    token("t4_err", 1'b1, "12G4 5\015", 32'h0, 1'b1, 1'b1);
    token("t4_next", 1'b0, "Q", 32'h51, 1'b0, 1'b0);
    // Nine digits: oldest digit shifted out
    token("t3_ovf", 1'b1, "123456789\n", 32'h2345_6789, 1'b1, 1'b0);

    // Reset in the middle of a number
    req_rx = 1'b1;
    type_rx = 1'b1;
    push(8'h31, ok);
    push(8'h32, ok);
    rst = 1'b0;
    #1;
    check("t6_rst_din", din_rx, 32'd0);
    check("t6_rst_flag", 32'(flag_rx), 32'd0);
    check("t6_rst_err", 32'(err_rx), 32'd0);
    check("t6_rst_rdy", 32'(rdy_rx), 32'd0);
    check("t6_rst_ack", 32'(ack_rx), 32'd0);
    req_rx = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    token("t6_after", 1'b1, "7 ", 32'h7, 1'b0, 1'b0);

    // Request dropped mid-number: no ack, next token starts clean
    c0 = ack_cnt;
    req_rx = 1'b1;
    type_rx = 1'b1;
    push(8'h33, ok);
    req_rx = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_ack", 32'(ack_cnt - c0), 32'd0);
    token("abort_next", 1'b1, "8 ", 32'h8, 1'b0, 1'b0);

    // Valid byte with no request is never taken
    c0 = ack_cnt;
    d_rx = 8'h5A;
    vld_rx = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("noreq_rdy", 32'(rdy_rx), 32'd0);
      @(negedge clk);
    end
    vld_rx = 1'b0;
    check("noreq_no_ack", 32'(ack_cnt - c0), 32'd0);
    token("noreq_next", 1'b0, "K", 32'h4B, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
